// File: rtl/deser_rr_arbiter.sv
// Round-robin scheduler that shares one deserializer between N serial lanes.
// A lane is granted for exactly one DATA_WIDTH-bit word. Its bit stream is
// muxed onto the deserializer input, and the lane index is emitted so that it
// lines up with the deserializer's registered word-valid pulse.
module deser_rr_arbiter #(
    parameter int N_LANES    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [N_LANES-1:0]         req_i,
    input  logic [N_LANES-1:0]         data_i,
    input  logic [N_LANES-1:0]         data_val_i,
    output logic [N_LANES-1:0]         grant_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic [$clog2(N_LANES)-1:0] lane_id_o,
    output logic                       lane_id_val_o,
    output logic                       err_o
);

    localparam int IW = $clog2(N_LANES);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] LAST_LANE = IW'(N_LANES - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [IW-1:0]     last;       // most recently granted lane (rr pointer)
    logic [IW-1:0]     gnt_idx;    // binary index of the granted lane
    logic [CW-1:0]     bit_cnt;    // accepted bits of the current word

    logic [IW-1:0]     cand;
    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic [N_LANES-1:0] win_onehot;
    logic              busy;
    logic              accept;
    logic              word_done;

    // Round-robin pick: first requesting lane at or after last+1, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cand    = '0;
        win_idx = last;
        win_any = |req_i;
        // Walk from farthest to nearest so the nearest requester overwrites.
        for (int i = N_LANES; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % N_LANES);
            if (req_i[cand]) begin
                win_idx = cand;
            end
        end
        win_onehot = N_LANES'(1) << win_idx;
    end

    // Data mux from the registered grant; nothing passes through while idle.
    always_comb begin
        busy           = (state == BUSY);
        accept         = busy && data_val_i[gnt_idx];
        ser_data_val_o = accept;
        ser_data_o     = busy && data_i[gnt_idx];
        word_done      = accept && (bit_cnt == LAST_CNT);
    end

    // Grant FSM, bit counter, lane tagging and protocol-error flag.
    always_ff @(posedge clk_i) begin
        // NOTE: all state is reset synchronously here; there is no memory array to leave uninitialised.
        if (srst_i) begin
            state         <= IDLE;
            last          <= LAST_LANE;
            gnt_idx       <= '0;
            bit_cnt       <= '0;
            grant_o       <= '0;
            lane_id_o     <= '0;
            lane_id_val_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            lane_id_val_o <= 1'b0;
            err_o         <= |(data_val_i & ~grant_o);

            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant_o <= win_onehot;
                        gnt_idx <= win_idx;
                        last    <= win_idx;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (word_done) begin
                            bit_cnt       <= '0;
                            lane_id_o     <= gnt_idx;
                            lane_id_val_o <= 1'b1;
                            // Re-arbitrate on the last bit; the served lane is
                            // now lowest priority because last == gnt_idx.
                            if (win_any) begin
                                grant_o <= win_onehot;
                                gnt_idx <= win_idx;
                                last    <= win_idx;
                            end else begin
                                grant_o <= '0;
                                state   <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Bench for deser_rr_arbiter: directed lane traffic with a scoreboard.
// Stimulus pushes the expected {lane, word} when it starts sending a word.
// A negedge monitor models the attached deserializer (MSB first), pops the
// queue on every lane_id_val_o pulse and compares.
module tb_deser_rr_arbiter;

    localparam int N_LANES    = 4;
    localparam int DATA_WIDTH = 16;

    logic                 clk_i;
    logic                 srst_i;
    logic [N_LANES-1:0]   req_i;
    logic [N_LANES-1:0]   data_i;
    logic [N_LANES-1:0]   data_val_i;
    logic [N_LANES-1:0]   grant_o;
    logic                 ser_data_o;
    logic                 ser_data_val_o;
    logic [1:0]           lane_id_o;
    logic                 lane_id_val_o;
    logic                 err_o;

    deser_rr_arbiter #(
        .N_LANES   (N_LANES),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .req_i         (req_i),
        .data_i        (data_i),
        .data_val_i    (data_val_i),
        .grant_o       (grant_o),
        .ser_data_o    (ser_data_o),
        .ser_data_val_o(ser_data_val_o),
        .lane_id_o     (lane_id_o),
        .lane_id_val_o (lane_id_val_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          lane;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          err_seen = 0;
    int          cyc = 0;
    int          last_pulse = 0;
    int          prev_pulse = 0;
    logic [15:0] deser_sr = '0;
    int          deser_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Deserializer model plus scoreboard consumer, sampled mid-cycle.
    always @(negedge clk_i) begin
        cyc++;
        if (srst_i) begin
            deser_sr  = '0;
            deser_cnt = 0;
        end else begin
            check("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
            if (grant_o == '0) begin
                check("idle_ser_val", 32'(ser_data_val_o), 32'd0);
            end
            if (err_o) begin
                err_seen++;
            end
            if (lane_id_val_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_lane_id_val", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("lane_id", 32'(lane_id_o), 32'(mon_e.lane));
                    check("word", 32'(deser_sr), 32'(mon_e.word));
                    check("bits_per_word", 32'(deser_cnt), 32'(DATA_WIDTH));
                end
                deser_cnt  = 0;
                prev_pulse = last_pulse;
                last_pulse = cyc;
            end
            if (ser_data_val_o) begin
                deser_sr = {deser_sr[14:0], ser_data_o};
                deser_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        srst_i     = 1'b1;
        req_i      = '0;
        data_i     = '0;
        data_val_i = '0;
        tick();
        tick();
        srst_i = 1'b0;
    endtask

    // Send one word on a lane once it is granted. Optional gap of invalid
    // cycles before bit gap_at, and req_i replaced by req_after when bit
    // req_bit is driven. immediate: the grant must already be present.
    task automatic serve(input int lane, input logic [15:0] word, input bit immediate,
                         input int gap_at, input int gap_len,
                         input int req_bit, input logic [3:0] req_after);
        int waited = 0;
        exp_q.push_back('{lane, word});
        if (immediate) begin
            check("grant_back_to_back", 32'(grant_o), 32'(4'b0001 << lane));
        end
        while (!grant_o[lane] && waited < 50) begin
            tick();
            waited++;
        end
        if (!grant_o[lane]) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (b == gap_at) begin
                repeat (gap_len) begin
                    data_val_i[lane] = 1'b0;
                    tick();
                end
            end
            if (b == req_bit) begin
                req_i = req_after;
            end
            data_i[lane]     = word[15-b];
            data_val_i[lane] = 1'b1;
            tick();
        end
        data_val_i[lane] = 1'b0;
        data_i[lane]     = 1'b0;
    endtask

    initial begin
        srst_i     = 1'b1;
        req_i      = '0;
        data_i     = '0;
        data_val_i = '0;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_lane_id", 32'(lane_id_o), 32'd0);
        check("rst_lane_id_val", 32'(lane_id_val_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_ser_val", 32'(ser_data_val_o), 32'd0);

        // Single lane 2, word A5C3, grant one cycle after request
        req_i = 4'b0100;
        check("t1_grant_before_edge", 32'(grant_o), 32'd0);
        tick();
        check("t1_grant", 32'(grant_o), 32'b0100);
        serve(2, 16'hA5C3, 1'b0, -1, 0, 0, 4'b0000);
        check("t1_grant_released", 32'(grant_o), 32'd0);
        tick();

        // All lanes request: order 0,1,2,3,0 with no idle bubble
        do_reset();
        req_i = 4'b1111;
        tick();
        check("t2_first_grant", 32'(grant_o), 32'b0001);
        serve(0, 16'h1234, 1'b0, -1, 0, -1, 4'b1111);
        serve(1, 16'h5678, 1'b1, -1, 0, -1, 4'b1111);
        serve(2, 16'h9ABC, 1'b1, -1, 0, -1, 4'b1111);
        serve(3, 16'hDEF0, 1'b1, -1, 0, -1, 4'b1111);
        serve(0, 16'h0F0F, 1'b1, -1, 0, 0, 4'b0000);
        check("t2_grant_released", 32'(grant_o), 32'd0);
        tick();

        // Lane 1 with a 5-cycle gap, drops req after bit 8; grant is held
        req_i = 4'b0010;
        tick();
        check("t3_grant", 32'(grant_o), 32'b0010);
        serve(1, 16'hBEEF, 1'b0, 6, 5, 8, 4'b0000);
        check("t3_grant_released", 32'(grant_o), 32'd0);
        tick();

        // Idle: lane 3 drives valid without grant -> err per offending cycle
        begin
            int err_base;
            tick();
            err_base = err_seen;
            data_i[3]     = 1'b1;
            data_val_i[3] = 1'b1;
            check("t4_ser_val_blocked", 32'(ser_data_val_o), 32'd0);
            check("t4_ser_data_blocked", 32'(ser_data_o), 32'd0);
            tick();
            check("t4_err_pulse", 32'(err_o), 32'd1);
            data_val_i[3] = 1'b0;
            tick();
            check("t4_err_clear", 32'(err_o), 32'd0);
            data_val_i[3] = 1'b1;
            tick();
            tick();
            data_val_i[3] = 1'b0;
            data_i[3]     = 1'b0;
            tick();
            tick();
            check("t4_err_count", 32'(err_seen - err_base), 32'd3);
        end

        // Reset after 7 bits of lane 2, then lane 0 wins first
        do_reset();
        req_i = 4'b0100;
        tick();
        check("t5_grant", 32'(grant_o), 32'b0100);
        for (int b = 0; b < 7; b++) begin
            data_i[2]     = b[0];
            data_val_i[2] = 1'b1;
            tick();
        end
        srst_i        = 1'b1;
        data_val_i[2] = 1'b0;
        data_i[2]     = 1'b0;
        req_i         = 4'b0101;
        tick();
        check("t5_rst_grant", 32'(grant_o), 32'd0);
        check("t5_rst_lane_id_val", 32'(lane_id_val_o), 32'd0);
        srst_i = 1'b0;
        tick();
        check("t5_lane0_first", 32'(grant_o), 32'b0001);
        serve(0, 16'h8001, 1'b0, -1, 0, -1, 4'b0101);
        serve(2, 16'h7FFE, 1'b1, -1, 0, 0, 4'b0000);
        check("t5_grant_released", 32'(grant_o), 32'd0);
        tick();

        // Only lane 0 requests: re-granted back-to-back, pulses 16 apart
        req_i = 4'b0001;
        tick();
        check("t6_grant", 32'(grant_o), 32'b0001);
        serve(0, 16'hFFFF, 1'b0, -1, 0, -1, 4'b0001);
        serve(0, 16'h0000, 1'b1, -1, 0, -1, 4'b0001);
        serve(0, 16'hAAAA, 1'b1, -1, 0, 0, 4'b0000);
        check("t6_grant_released", 32'(grant_o), 32'd0);
        tick();
        tick();
        check("t6_pulse_spacing", 32'(last_pulse - prev_pulse), 32'(DATA_WIDTH));

        repeat (3) tick();
        check("all_words_delivered", 32'(exp_q.size()), 32'd0);
        check("total_err_pulses", 32'(err_seen), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
